// File: rtl/fifo_pkg.sv
// Shared types and constants for the Ethernet async FIFO read-side output stage.
package fifo_pkg;

  localparam int BEAT_DATA_W = 8;
  localparam int BUF_DEPTH   = 3;

  typedef logic [1:0] buf_ptr_t;

  typedef struct packed {
    logic                   last;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;

  // Pointers walk 0,1,2 and wrap back to 0.
  function automatic buf_ptr_t ptr_inc(input buf_ptr_t p);
    return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? buf_ptr_t'(0) : p + buf_ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_prefetch_buf.sv
// Three-entry circular prefetch buffer holding beats read from the FIFO RAM.
module fifo_prefetch_buf
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head_beat,
  output logic [1:0] occ
);

  beat_t      mem_q [BUF_DEPTH];
  beat_t      mem_d [BUF_DEPTH];
  buf_ptr_t   head_q, head_d;
  buf_ptr_t   tail_q, tail_d;
  logic [1:0] occ_q, occ_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push) begin
      mem_d[tail_q] = push_beat;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
    end
    // A simultaneous push and pop leaves the occupancy unchanged.
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign head_beat = mem_q[head_q];
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_axis_rd_adapter.sv
// Read-side AXI-Stream adapter for the async FIFO: issues RAM reads and prefetches beats.
// Define FIFO_AXIS_FRAME_CNT_EN to build the completed-frame counter on frame_cnt.
module fifo_axis_rd_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = BEAT_DATA_W,
  parameter int BUF_DEPTH  = fifo_pkg::BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  output logic                  read,
  input  logic [DATA_WIDTH:0]   rd_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           frame_cnt
);

  logic       inflight_q, inflight_d;
  logic [1:0] occ;
  logic [2:0] pending;
  logic       pop;
  beat_t      push_beat;
  beat_t      head_beat;

  assign pending = {1'b0, occ} + {2'b00, inflight_q};

  // The issue decision uses registered occupancy only, never tready, so a full
  // buffer popping this cycle resumes issuing one cycle later.
  always_comb begin
    read       = 1'b0;
    inflight_d = 1'b0;
    if (!reset && !empty && (pending < 3'(BUF_DEPTH))) begin
      read = 1'b1;
    end
    inflight_d = read;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign push_beat     = '{last: rd_data[DATA_WIDTH], data: rd_data[DATA_WIDTH-1:0]};
  assign m_axis_tvalid = (occ != 2'd0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = head_beat.data;
  assign m_axis_tlast  = head_beat.last;

  fifo_prefetch_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_q),
    .push_beat (push_beat),
    .pop       (pop),
    .head_beat (head_beat),
    .occ       (occ)
  );

`ifdef FIFO_AXIS_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pop && m_axis_tlast) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: doc/fifo_axis_rd_adapter.md
# fifo_axis_rd_adapter

Read-side output stage of the Ethernet async FIFO. It sits directly downstream of the FIFO read-pointer logic and the dual-port RAM, in the read clock domain. It converts the pointer block's `empty`/`read` interface and the RAM's registered read port into an AXI-Stream master. A small prefetch buffer absorbs the one-cycle RAM read latency and sustains one beat per clock under arbitrary `tready` back-pressure.

## Interface
Parameters:
- `DATA_WIDTH`, 8: payload width of one beat.
- `BUF_DEPTH`, 3: prefetch buffer entries. Fixed at 3; other values are unsupported.

Ports:
- `clk` in 1: read-domain clock.
- `reset` in 1: asynchronous, active-high reset.
- `empty` in 1: registered empty flag from the read-pointer block.
- `read` out 1: read strobe to the read-pointer block; advances `rd_addr`.
- `rd_data` in DATA_WIDTH+1: RAM read data, valid the cycle after `read`. Bit [DATA_WIDTH] is tlast; bits [DATA_WIDTH-1:0] are payload.
- `m_axis_tdata` out DATA_WIDTH: stream payload.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tlast` out 1: end-of-frame marker.
- `m_axis_tready` in 1: downstream ready.
- `frame_cnt` out 16: completed-frame count (see Configuration).

## Operation
- Reset values: `read`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `frame_cnt`=0. Occupancy, in-flight flag and buffer pointers are all 0.
- State:
  - `occ` (0..3): number of buffered beats.
  - `inflight` (0/1): a read was issued last cycle.
  - Buffer head and tail pointers (2-bit, wrap 2→0).
- Issue rule: `read` = !empty && (occ + inflight < 3). It is combinational from registered state and `empty` only. It must never depend on `m_axis_tready`.
- Capture: when `inflight`=1, write `rd_data` into the entry at the tail, then advance the tail.
- Pop: when `m_axis_tvalid && m_axis_tready`, advance the head.
- Occupancy update: occ_next = occ + inflight − pop. If capture and pop happen in the same cycle, occ is unchanged.
- Output: `m_axis_tvalid` = (occ != 0). `m_axis_tdata`/`m_axis_tlast` come from the head entry.
  - Once tvalid is asserted, tdata and tlast stay stable until the handshake (AXI rule).
  - tvalid is never dropped without a handshake.
- `empty` is trusted as registered by the pointer block. A read issued while `empty` deasserts in the same cycle is legal, because the pointer block gates it.
- No frame reassembly. Beats pass through in FIFO order; tlast is forwarded unchanged.

## Timing
- Latency: if `empty` falls at edge E, `read` is high in the following cycle. Data is captured at edge E+2, and `m_axis_tvalid` is high after edge E+2, i.e. 2 cycles.
- Throughput: with tready held at 1 and `empty`=0, one beat transfers every cycle indefinitely.
- Back-pressure: with tready=0, reads continue until occ + inflight = 3, then stop. No beat is lost or duplicated.
- Buffer full and pop in the same cycle: `read` stays off that cycle, because the issue rule uses registered occ. Issuing resumes the next cycle.
- Empty mid-stream: buffered beats still drain. tvalid falls the cycle after the last pop.
- Reset mid-operation: all outputs clear asynchronously. In-flight and buffered beats are discarded. The pointer block is reset concurrently by the top level.

## Configuration
- `FIFO_AXIS_FRAME_CNT_EN` defined:
  - `frame_cnt` increments by 1 on every handshake with `m_axis_tlast`=1.
  - It wraps 0xFFFF→0x0000 and clears on reset.
- Not defined: `frame_cnt` is tied to 0 and no counter logic is synthesised. The port remains present.

## Structure
- Shared package `fifo_pkg` holds:
  - The beat typedef: struct of `last` plus `data`, parameterised by DATA_WIDTH via localparam.
  - The `BUF_DEPTH` constant.
  - The 2-bit buffer pointer typedef.
- Sub-module `fifo_prefetch_buf`: a 3-entry circular buffer with push/pop, head/tail pointers and occ. The top level holds the issue logic, the in-flight flag and the frame counter.

## Test plan
- Reset: assert `reset` mid-transfer with occ=2 → tvalid, read and frame_cnt become 0 immediately. After release, the first beat output is the next RAM word.
- Streaming: empty=0, tready=1, feed words 0x00..0x3F with tlast on 0x3F → 64 consecutive handshakes with no bubble after the first; first tvalid 2 cycles after empty falls.
- Back-pressure: hold tready=0 for 10 cycles during a stream → exactly 3 reads issued, then read=0; tdata holds 0x05 stable. Release → beats 0x05, 0x06, 0x07 follow in order.
- Random tready: 50% random tready over 1000 beats → output sequence identical to input, and occ + inflight never exceeds 3.
- Drain on empty: empty rises after word 0x10 is read, tready=1 → remaining buffered beats delivered, tvalid low the cycle after 0x10 pops, read stays 0.
- Frame counter: with FIFO_AXIS_FRAME_CNT_EN, send 3 frames of lengths 1, 4 and 60 → frame_cnt = 3. Without the macro → frame_cnt = 0 throughout.
